// File: rtl/vend_session_ctrl.sv
// ---------------------------------------------------------------------------
// vend_session_ctrl
//   Session controller for the vending datapath. Accumulates coin credit
//   (1 unit = one 5c coin), validates a product selection against a two-entry
//   price table, sequences the dispenser over req/ack, then pays change back
//   one coin unit at a time through the hopper.
//
// Ports
//   clk, rst         rising-edge clock; asynchronous active-high reset
//   coin5, coin10    1-cycle coin pulses (+1 / +2 units; both at once = +3)
//   sel[1:0]         1-cycle select pulse: 01 = A, 10 = B, 11 = invalid
//   cancel           1-cycle pulse: abort session and refund credit
//   disp_req/disp_id dispense request and product id (0 = A, 1 = B)
//   disp_ack         dispenser done
//   chg_req/chg_ack  release-one-coin request and its acknowledge
//   credit           current credit in units
//   busy             high while dispensing or paying change
//   coin_rej         1-cycle pulse: coin refused (busy or overflow)
//   err_insuff       1-cycle pulse: selection refused (low credit / invalid)
//   state_dbg        current FSM state (0 IDLE, 1 CREDIT, 2 DISPENSE, 3 CHANGE)
//
// Configuration
//   VEND_TIMEOUT_EN  when defined, TIMEOUT_CYC idle cycles in CREDIT trigger
//                    an automatic refund (CREDIT -> CHANGE). When undefined,
//                    credit is held in CREDIT indefinitely.
//
// Handshake: disp_req (with disp_id) and chg_req are levels that stay high
// until the matching ack is seen high on a rising edge while the request is
// high; an ack arriving while its request is low is ignored. Each accepted
// chg_ack releases exactly one coin unit.
// ---------------------------------------------------------------------------
module vend_session_ctrl #(
  parameter int CREDIT_W    = 5,
  parameter int PRICE_A     = 3,
  parameter int PRICE_B     = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin5,
  input  logic                coin10,
  input  logic [1:0]          sel,
  input  logic                cancel,
  output logic                disp_req,
  output logic                disp_id,
  input  logic                disp_ack,
  output logic                chg_req,
  input  logic                chg_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_rej,
  output logic                err_insuff,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_A_U = CREDIT_W'(PRICE_A);
  localparam logic [CREDIT_W-1:0] PRICE_B_U = CREDIT_W'(PRICE_B);

  // Elaboration-time sanity check on the configuration.
  if (CREDIT_W < 2 || PRICE_A < 1 || PRICE_B < 1 || TIMEOUT_CYC < 1 ||
      PRICE_A > (2**CREDIT_W - 1) || PRICE_B > (2**CREDIT_W - 1)) begin : g_param_check
    $error("vend_session_ctrl: illegal parameter combination");
  end

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  disp_req_q, disp_req_d;
  logic                  disp_id_q, disp_id_d;
  logic                  chg_req_q, chg_req_d;
  logic                  busy_q, busy_d;
  logic                  coin_rej_q, coin_rej_d;
  logic                  err_q, err_d;

  logic [1:0]            coin_add;
  logic [CREDIT_W:0]     coin_sum;
  logic                  coin_ok;

`ifdef VEND_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]      idle_cnt_q, idle_cnt_d;
`endif

  // coin5 + 2*coin10 is simply the two pulses read as a 2-bit number. The
  // extra sum bit is the overflow flag since CREDIT_MAX = 2**CREDIT_W-1.
  assign coin_add = {coin10, coin5};
  assign coin_sum = {1'b0, credit_q} + {{(CREDIT_W-1){1'b0}}, coin_add};
  assign coin_ok  = (coin_add != 2'b00) && !coin_sum[CREDIT_W];

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    disp_id_d  = disp_id_q;
    coin_rej_d = 1'b0;
    err_d      = 1'b0;
`ifdef VEND_TIMEOUT_EN
    idle_cnt_d = '0;
`endif

    case (state_q)
      S_IDLE, S_CREDIT: begin
        // Coins are processed independently of sel/cancel in the same cycle;
        // an overflowing add is refused as a whole.
        credit_d   = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
        coin_rej_d = (coin_add != 2'b00) && !coin_ok;
        state_d    = (credit_d != '0) ? S_CREDIT : S_IDLE;

        if (state_q == S_CREDIT && cancel) begin
          // cancel beats a simultaneous sel
          state_d = S_CHANGE;
        end else if (sel != 2'b00) begin
          // Affordability uses the pre-coin credit; a same-cycle coin still
          // lands in the remaining balance.
          if (state_q == S_CREDIT && sel == 2'b01 && credit_q >= PRICE_A_U) begin
            state_d   = S_DISPENSE;
            disp_id_d = 1'b0;
            credit_d  = credit_d - PRICE_A_U;
          end else if (state_q == S_CREDIT && sel == 2'b10 && credit_q >= PRICE_B_U) begin
            state_d   = S_DISPENSE;
            disp_id_d = 1'b1;
            credit_d  = credit_d - PRICE_B_U;
          end else begin
            err_d = 1'b1;
          end
        end

`ifdef VEND_TIMEOUT_EN
        // Only truly idle CREDIT cycles advance the counter; any accepted
        // coin, sel or cancel leaves it at its default of zero.
        if (state_q == S_CREDIT && !cancel && !coin_ok && sel == 2'b00) begin
          if (idle_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d = S_CHANGE;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
`endif
      end

      S_DISPENSE: begin
        coin_rej_d = (coin_add != 2'b00);
        if (disp_ack) begin
          state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
        end
      end

      S_CHANGE: begin
        coin_rej_d = (coin_add != 2'b00);
        if (credit_q == '0) begin
          state_d = S_IDLE;
        end else if (chg_ack) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // disp_id is only meaningful alongside disp_req; park it at 0 otherwise.
    if (state_d != S_DISPENSE) begin
      disp_id_d = 1'b0;
    end

    disp_req_d = (state_d == S_DISPENSE);
    chg_req_d  = (state_d == S_CHANGE);
    busy_d     = (state_d == S_DISPENSE) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      credit_q   <= '0;
      disp_req_q <= 1'b0;
      disp_id_q  <= 1'b0;
      chg_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      coin_rej_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      idle_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      disp_req_q <= disp_req_d;
      disp_id_q  <= disp_id_d;
      chg_req_q  <= chg_req_d;
      busy_q     <= busy_d;
      coin_rej_q <= coin_rej_d;
      err_q      <= err_d;
`ifdef VEND_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  assign disp_req   = disp_req_q;
  assign disp_id    = disp_id_q;
  assign chg_req    = chg_req_q;
  assign credit     = credit_q;
  assign busy       = busy_q;
  assign coin_rej   = coin_rej_q;
  assign err_insuff = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_vend_session_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vend_session_ctrl
//   Directed session scenarios followed by randomized coin/select/cancel/ack
//   traffic. A behavioural model of the vending rules predicts the complete
//   output vector for every clock; a monitor process compares the DUT against
//   the predictions in order.
// ---------------------------------------------------------------------------
module tb_vend_session_ctrl;

  localparam int CREDIT_W    = 5;
  localparam int CREDIT_MAX  = 31;
  localparam int PRICE_A     = 3;
  localparam int PRICE_B     = 4;
  localparam int TIMEOUT_CYC = 1000;
  localparam int OUT_W       = 11;

  localparam int PH_IDLE   = 0;
  localparam int PH_CREDIT = 1;
  localparam int PH_DISP   = 2;
  localparam int PH_CHANGE = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                coin5, coin10, cancel, disp_ack, chg_ack;
  logic [1:0]          sel;
  logic                disp_req, disp_id, chg_req, busy, coin_rej, err_insuff;
  logic [CREDIT_W-1:0] credit;
  logic [1:0]          state_dbg;

  vend_session_ctrl #(
    .CREDIT_W    (CREDIT_W),
    .PRICE_A     (PRICE_A),
    .PRICE_B     (PRICE_B),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin5      (coin5),
    .coin10     (coin10),
    .sel        (sel),
    .cancel     (cancel),
    .disp_req   (disp_req),
    .disp_id    (disp_id),
    .disp_ack   (disp_ack),
    .chg_req    (chg_req),
    .chg_ack    (chg_ack),
    .credit     (credit),
    .busy       (busy),
    .coin_rej   (coin_rej),
    .err_insuff (err_insuff),
    .state_dbg  (state_dbg)
  );

  logic [OUT_W-1:0] dut_vec;
  assign dut_vec = {disp_req, disp_id, chg_req, credit, busy, coin_rej, err_insuff};

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_vec(input string name, input logic [OUT_W-1:0] got,
                           input logic [OUT_W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %b required %b (disp_req,disp_id,chg_req,credit[4:0],busy,coin_rej,err_insuff)",
               name, $time, got, exp);
    end
  endtask

  // Monitor: one prediction per clock, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      check_vec("cycle_outs", dut_vec, exp_q.pop_front());
    end
  end

  // ---------------- reference model ----------------
  int m_phase, m_credit, m_id, m_idle;

  function automatic void model_reset();
    m_phase  = PH_IDLE;
    m_credit = 0;
    m_id     = 0;
    m_idle   = 0;
  endfunction

  // Predicts the outputs that follow one clock with the given inputs.
  function automatic void model_step(input logic c5, input logic c10,
                                     input logic [1:0] s, input logic can,
                                     input logic da, input logic ca);
    int add, nxt, newc, price;
    bit rej, err, quiet;
    logic [CREDIT_W-1:0] cv;
    add = (c5 ? 1 : 0) + (c10 ? 2 : 0);
    nxt = m_phase;
    newc = m_credit;
    rej = 0;
    err = 0;
    case (m_phase)
      PH_IDLE, PH_CREDIT: begin
        if (add > 0) begin
          if (m_credit + add > CREDIT_MAX) rej = 1;
          else newc = m_credit + add;
        end
        nxt = (newc > 0) ? PH_CREDIT : PH_IDLE;
        if (m_phase == PH_CREDIT && can) begin
          nxt = PH_CHANGE;
        end else if (s != 2'b00) begin
          price = (s == 2'b01) ? PRICE_A : (s == 2'b10) ? PRICE_B : 0;
          if (m_phase == PH_CREDIT && price > 0 && m_credit >= price) begin
            nxt  = PH_DISP;
            m_id = (s == 2'b10) ? 1 : 0;
            newc = newc - price;
          end else begin
            err = 1;
          end
        end
        quiet = (m_phase == PH_CREDIT) && !can && s == 2'b00 && !(add > 0 && !rej);
`ifdef VEND_TIMEOUT_EN
        if (quiet) begin
          m_idle++;
          if (m_idle == TIMEOUT_CYC) nxt = PH_CHANGE;
        end else begin
          m_idle = 0;
        end
`endif
      end
      PH_DISP: begin
        rej = (add > 0);
        if (da) nxt = (m_credit > 0) ? PH_CHANGE : PH_IDLE;
      end
      default: begin
        rej = (add > 0);
        if (ca) begin
          newc = newc - 1;
          if (newc == 0) nxt = PH_IDLE;
        end
      end
    endcase
    if (nxt != PH_CREDIT) m_idle = 0;
    if (nxt != PH_DISP) m_id = 0;
    cv = CREDIT_W'(newc);
    exp_q.push_back({(nxt == PH_DISP), (m_id == 1), (nxt == PH_CHANGE), cv,
                     (nxt == PH_DISP || nxt == PH_CHANGE), rej, err});
    m_phase  = nxt;
    m_credit = newc;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    coin5 = 0; coin10 = 0; sel = 2'b00; cancel = 0; disp_ack = 0; chg_ack = 0;
  endtask

  task automatic step(input logic c5, input logic c10, input logic [1:0] s,
                      input logic can, input logic da, input logic ca);
    @(negedge clk);
    coin5 = c5; coin10 = c10; sel = s; cancel = can; disp_ack = da; chg_ack = ca;
    model_step(c5, c10, s, can, da, ca);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, 0, 0);
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #1;
    check_vec("async_reset_outs", dut_vec, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    logic [1:0] s;
    clear_inputs();
    rst = 1'b1;
    model_reset();
    #2;
    check_vec("reset_outs", dut_vec, '0);

    // 1: exact payment for A, no change
    do_reset();
    step(0, 1, 2'b00, 0, 0, 0);
    step(1, 0, 2'b00, 0, 0, 0);
    step(0, 0, 2'b01, 0, 0, 0);
    idle(2);
    step(0, 0, 2'b00, 0, 1, 0);
    idle(2);

    // 2: overpay for B, two coins change
    step(0, 1, 2'b00, 0, 0, 0);
    step(0, 1, 2'b00, 0, 0, 0);
    step(0, 1, 2'b00, 0, 0, 0);
    step(0, 0, 2'b10, 0, 0, 0);
    step(0, 0, 2'b00, 0, 1, 0);
    idle(1);
    step(0, 0, 2'b00, 0, 0, 1);
    idle(1);
    step(0, 0, 2'b00, 0, 0, 1);
    idle(1);

    // 3: refused selections, then cancel refund
    step(1, 0, 2'b00, 0, 0, 0);
    step(0, 0, 2'b10, 0, 0, 0);
    step(0, 0, 2'b11, 0, 0, 0);
    step(0, 0, 2'b01, 1, 0, 0);
    idle(1);
    step(0, 0, 2'b00, 0, 0, 1);
    step(0, 0, 2'b01, 0, 0, 0);

    // 4: coin while busy, overflow at the top of the range
    step(1, 1, 2'b00, 0, 0, 0);
    step(0, 0, 2'b01, 0, 0, 0);
    step(1, 0, 2'b00, 0, 0, 0);
    step(0, 0, 2'b00, 0, 1, 0);
    for (int i = 0; i < 15; i++) step(0, 1, 2'b00, 0, 0, 0);
    step(0, 1, 2'b00, 0, 0, 0);
    step(1, 1, 2'b00, 0, 0, 0);
    step(1, 0, 2'b00, 0, 0, 0);
    step(1, 0, 2'b00, 0, 0, 0);
    step(0, 0, 2'b00, 1, 0, 0);
    for (int i = 0; i < 31; i++) step(1, 0, 2'b00, 0, 0, 1);
    idle(2);

    // 5: simultaneous coins; select with a same-cycle coin
    step(1, 1, 2'b00, 0, 0, 0);
    step(1, 0, 2'b01, 0, 0, 0);
    step(0, 0, 2'b00, 0, 1, 0);
    step(0, 0, 2'b00, 0, 0, 1);
    idle(1);

    // 6: reset in the middle of a dispense
    step(0, 1, 2'b00, 0, 0, 0);
    step(1, 0, 2'b00, 0, 0, 0);
    step(0, 0, 2'b01, 0, 0, 0);
    do_reset();
    idle(1);

`ifdef VEND_TIMEOUT_EN
    step(1, 0, 2'b00, 0, 0, 0);
    idle(TIMEOUT_CYC);
    step(0, 0, 2'b00, 0, 0, 1);
    idle(2);
`endif

    // randomized sessions
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 7);
        s = (r == 1) ? 2'b01 : (r == 2) ? 2'b10 : (r == 3) ? 2'b11 : 2'b00;
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), s,
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 2) == 0));
      end
    end
    idle(1);

    @(negedge clk);
    clear_inputs();
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
